// File: rtl/bp_be_fe_cmd_sequencer.sv
// BE->FE command sequencer: fixed-priority arbitration of redirect and maintenance
// requesters onto the single FE command channel, with fence drain and a fence timeout.
module bp_be_fe_cmd_sequencer #(
    parameter int unsigned num_req_p       = 4,
    parameter int unsigned fe_cmd_width_p  = 109,
    parameter int unsigned fence_timeout_p = 255
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p*fe_cmd_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                req_fence_i,
    output logic [num_req_p-1:0]                req_yumi_o,
    output logic [fe_cmd_width_p-1:0]           fe_cmd_o,
    output logic                                fe_cmd_v_o,
    input  logic                                fe_cmd_ready_i,
    input  logic                                fe_cmd_fence_i,
    output logic                                suppress_iss_o,
    output logic                                fence_timeout_o,
    output logic [15:0]                         cmd_count_o
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SEND       = 2'd1;
    localparam logic [1:0] FENCE_WAIT = 2'd2;

    localparam logic [7:0] timeout_lp = 8'(fence_timeout_p);

    logic [1:0]                state_q,      state_d;
    logic [fe_cmd_width_p-1:0] hold_q,       hold_d;
    logic                      hold_fence_q, hold_fence_d;
    logic [7:0]                fence_cnt_q,  fence_cnt_d;
    logic                      timeout_q,    timeout_d;
    logic [15:0]               count_q,      count_d;

    logic [num_req_p-1:0]      grant_oh;
    logic [fe_cmd_width_p-1:0] grant_cmd;
    logic                      grant_fence;
    logic                      any_req;
    logic                      can_load;
    logic                      load;
    logic                      accept;

    // Walk from the top index down so the lowest set bit is the one left standing.
    always_comb begin
        grant_oh = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (req_v_i[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_cmd = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_oh[i]) begin
                grant_cmd = req_cmd_i[i*fe_cmd_width_p +: fe_cmd_width_p];
            end
        end
    end

    assign grant_fence = |(grant_oh & req_fence_i);
    assign any_req     = |req_v_i;
    assign can_load    = (state_q == IDLE)
                       | ((state_q == SEND) & fe_cmd_ready_i & ~hold_fence_q);
    assign load        = can_load & any_req;
    assign accept      = (state_q == SEND) & fe_cmd_ready_i;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_fence_d = hold_fence_q;
        fence_cnt_d  = fence_cnt_q;
        timeout_d    = timeout_q;
        count_d      = accept ? count_q + 16'd1 : count_q;

        if (load) begin
            hold_d       = grant_cmd;
            hold_fence_d = grant_fence;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fe_cmd_ready_i) begin
                    if (hold_fence_q) begin
                        state_d     = FENCE_WAIT;
                        fence_cnt_d = '0;
                    end else if (any_req) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FENCE_WAIT: begin
                if (!fe_cmd_fence_i) begin
                    state_d = IDLE;
                end else begin
                    fence_cnt_d = fence_cnt_q + 8'd1;
                    if (fence_cnt_d == timeout_lp) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_fence_q <= 1'b0;
            fence_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_fence_q <= hold_fence_d;
            fence_cnt_q  <= fence_cnt_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the combinational outputs are gated by reset so they also read 0 while reset is held.
    assign req_yumi_o      = grant_oh & {num_req_p{load & reset_n_i}};
    assign suppress_iss_o  = reset_n_i & ((state_q != IDLE) | any_req);
    assign fe_cmd_v_o      = (state_q == SEND);
    assign fe_cmd_o        = hold_q;
    assign fence_timeout_o = timeout_q;
    assign cmd_count_o     = count_q;

    // A grant is at most one requester, and an offered command holds still until accepted.
    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(req_yumi_o));
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fe_cmd_v_o && !fe_cmd_ready_i) |=> (fe_cmd_v_o && $stable(fe_cmd_o)));

endmodule

// File: tb/tb_bp_be_fe_cmd_sequencer.sv
// Bench for bp_be_fe_cmd_sequencer: directed scenarios plus randomized traffic,
// all scored against a transaction-level model of the command channel.
module tb_bp_be_fe_cmd_sequencer;

    localparam int N = 4;
    localparam int W = 109;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_v;
    logic [N-1:0]   req_fence;
    logic [W-1:0]   cmds [N];
    logic [N*W-1:0] req_cmd;
    logic [N-1:0]   yumi;
    logic [W-1:0]   fe_cmd;
    logic           fe_v;
    logic           ready;
    logic           fence_i;
    logic           supp;
    logic           tmo;
    logic [15:0]    count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the offered command, whether a fence drain is in progress, and counters.
    bit           m_valid;
    logic [W-1:0] m_cmd;
    bit           m_fence;
    bit           m_wait;
    int           m_wait_cnt;
    bit           m_flag;
    int           m_count;

    always #5 clk = ~clk;

    always_comb begin
        req_cmd = '0;
        for (int i = 0; i < N; i++) req_cmd[i*W +: W] = cmds[i];
    end

    bp_be_fe_cmd_sequencer #(
        .num_req_p      (N),
        .fe_cmd_width_p (W),
        .fence_timeout_p(255)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_v_i        (req_v),
        .req_cmd_i      (req_cmd),
        .req_fence_i    (req_fence),
        .req_yumi_o     (yumi),
        .fe_cmd_o       (fe_cmd),
        .fe_cmd_v_o     (fe_v),
        .fe_cmd_ready_i (ready),
        .fe_cmd_fence_i (fence_i),
        .suppress_iss_o (supp),
        .fence_timeout_o(tmo),
        .cmd_count_o    (count)
    );

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        int unsigned x;
        x = 32'(v);
        return N'(x & (~x + 32'd1));
    endfunction

    function automatic logic [W-1:0] rand_cmd();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_valid    = 0;
        m_cmd      = '0;
        m_fence    = 0;
        m_wait     = 0;
        m_wait_cnt = 0;
        m_flag     = 0;
        m_count    = 0;
    endtask

    // One clock: score outputs at the falling edge, advance the model, and let served requesters drop.
    task automatic tick();
        logic [N-1:0] y_exp;
        bit           free;
        bit           supp_exp;
        @(negedge clk);
        free     = !m_wait && (!m_valid || (ready && !m_fence));
        y_exp    = free ? lowest(req_v) : '0;
        supp_exp = m_valid || m_wait || (req_v != 0);

        n_cmp++;
        if (fe_v !== m_valid) begin
            n_err++;
            $display("FAIL model_valid: got %b want %b at %0t", fe_v, m_valid, $time);
        end
        if (m_valid) begin
            n_cmp++;
            if (fe_cmd !== m_cmd) begin
                n_err++;
                $display("FAIL model_cmd: got %h want %h at %0t", fe_cmd, m_cmd, $time);
            end
        end
        n_cmp++;
        if (yumi !== y_exp) begin
            n_err++;
            $display("FAIL model_yumi: got %b want %b at %0t", yumi, y_exp, $time);
        end
        n_cmp++;
        if (supp !== supp_exp) begin
            n_err++;
            $display("FAIL model_suppress: got %b want %b at %0t", supp, supp_exp, $time);
        end
        n_cmp++;
        if (tmo !== m_flag) begin
            n_err++;
            $display("FAIL model_timeout: got %b want %b at %0t", tmo, m_flag, $time);
        end
        n_cmp++;
        if (count !== 16'(m_count)) begin
            n_err++;
            $display("FAIL model_count: got %0d want %0d at %0t", count, m_count, $time);
        end

        if (m_valid && ready) m_count = (m_count + 1) % 65536;
        if (m_wait) begin
            if (!fence_i) begin
                m_wait = 0;
            end else begin
                m_wait_cnt++;
                if (m_wait_cnt == 255) begin
                    m_flag = 1;
                    m_wait = 0;
                end
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
            if (m_fence) begin
                m_wait     = 1;
                m_wait_cnt = 0;
            end
        end
        if (y_exp != 0) begin
            m_valid = 1;
            m_cmd   = cmds[$clog2(y_exp)];
            m_fence = req_fence[$clog2(y_exp)];
        end

        @(posedge clk);
        #1;
        req_v = req_v & ~y_exp;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_v     = 4'b0101;
        req_fence = '0;
        ready     = 1'b1;
        fence_i   = 1'b0;
        for (int i = 0; i < N; i++) cmds[i] = rand_cmd();
        model_reset();
        #3;
        n_cmp++;
        if (fe_v !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fe_v); end
        n_cmp++;
        if (yumi !== 4'b0000) begin n_err++; $display("FAIL reset_yumi: got %b want 0000", yumi); end
        n_cmp++;
        if (supp !== 1'b0) begin n_err++; $display("FAIL reset_suppress: got %b want 0", supp); end
        n_cmp++;
        if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", tmo); end
        n_cmp++;
        if (count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        req_v = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int           base;
        logic [W-1:0] c2;
        base     = m_count;
        c2       = rand_cmd();
        cmds[2]  = c2;
        ready    = 1'b1;
        req_v    = 4'b0100;
        #1;
        n_cmp++;
        if (yumi !== 4'b0100) begin n_err++; $display("FAIL single_yumi: got %b want 0100", yumi); end
        tick();
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c2) begin
            n_err++;
            $display("FAIL single_cmd: got v=%b %h want v=1 %h", fe_v, fe_cmd, c2);
        end
        tick();
        n_cmp++;
        if (fe_v !== 1'b0 || count !== 16'(base + 1)) begin
            n_err++;
            $display("FAIL single_done: got v=%b count=%0d want v=0 count=%0d", fe_v, count, base + 1);
        end
    endtask

    task automatic test_back_to_back();
        int           base;
        logic [W-1:0] c1, c3;
        base    = m_count;
        c1      = rand_cmd();
        c3      = rand_cmd();
        cmds[1] = c1;
        cmds[3] = c3;
        ready   = 1'b1;
        req_v   = 4'b1010;
        #1;
        n_cmp++;
        if (yumi !== 4'b0010) begin n_err++; $display("FAIL prio_first_yumi: got %b want 0010", yumi); end
        tick();
        #1;
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c1 || yumi !== 4'b1000) begin
            n_err++;
            $display("FAIL prio_req1: got v=%b yumi=%b %h want v=1 yumi=1000 %h", fe_v, yumi, fe_cmd, c1);
        end
        tick();
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c3) begin
            n_err++;
            $display("FAIL prio_req3: got v=%b %h want v=1 %h", fe_v, fe_cmd, c3);
        end
        tick();
        n_cmp++;
        if (fe_v !== 1'b0 || count !== 16'(base + 2)) begin
            n_err++;
            $display("FAIL prio_done: got v=%b count=%0d want v=0 count=%0d", fe_v, count, base + 2);
        end
    endtask

    task automatic test_backpressure();
        int           base;
        logic [W-1:0] c0;
        base    = m_count;
        c0      = rand_cmd();
        cmds[0] = c0;
        ready   = 1'b0;
        req_v   = 4'b0001;
        tick();
        cmds[2] = rand_cmd();
        req_v   = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (fe_v !== 1'b1 || fe_cmd !== c0 || yumi !== 4'b0000 || count !== 16'(base)) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b yumi=%b count=%0d %h want v=1 yumi=0000 count=%0d %h",
                         fe_v, yumi, count, fe_cmd, base, c0);
            end
            tick();
        end
        ready = 1'b1;
        #1;
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c0 || yumi !== 4'b0100) begin
            n_err++;
            $display("FAIL stall_release: got v=%b yumi=%b %h want v=1 yumi=0100 %h", fe_v, yumi, fe_cmd, c0);
        end
        tick();
        n_cmp++;
        if (count !== 16'(base + 1)) begin
            n_err++;
            $display("FAIL stall_count: got %0d want %0d", count, base + 1);
        end
        tick();
    endtask

    task automatic test_fence();
        int           base;
        logic [W-1:0] c0, c1;
        base         = m_count;
        c0           = rand_cmd();
        c1           = rand_cmd();
        cmds[0]      = c0;
        cmds[1]      = c1;
        req_fence    = 4'b0001;
        ready        = 1'b1;
        fence_i      = 1'b0;
        req_v        = 4'b0011;
        #1;
        n_cmp++;
        if (yumi !== 4'b0001) begin n_err++; $display("FAIL fence_first_yumi: got %b want 0001", yumi); end
        tick();
        #1;
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c0 || yumi !== 4'b0000 || supp !== 1'b1) begin
            n_err++;
            $display("FAIL fence_send: got v=%b yumi=%b supp=%b want v=1 yumi=0000 supp=1", fe_v, yumi, supp);
        end
        fence_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (fe_v !== 1'b0 || yumi !== 4'b0000 || supp !== 1'b1) begin
                n_err++;
                $display("FAIL fence_wait: got v=%b yumi=%b supp=%b want v=0 yumi=0000 supp=1", fe_v, yumi, supp);
            end
            tick();
        end
        fence_i = 1'b0;
        #1;
        n_cmp++;
        if (yumi !== 4'b0000 || supp !== 1'b1) begin
            n_err++;
            $display("FAIL fence_drain: got yumi=%b supp=%b want yumi=0000 supp=1", yumi, supp);
        end
        tick();
        #1;
        n_cmp++;
        if (yumi !== 4'b0010 || supp !== 1'b1) begin
            n_err++;
            $display("FAIL fence_after: got yumi=%b supp=%b want yumi=0010 supp=1", yumi, supp);
        end
        tick();
        n_cmp++;
        if (fe_v !== 1'b1 || fe_cmd !== c1) begin
            n_err++;
            $display("FAIL fence_next_cmd: got v=%b %h want v=1 %h", fe_v, fe_cmd, c1);
        end
        tick();
        req_fence = '0;
        n_cmp++;
        if (count !== 16'(base + 2)) begin
            n_err++;
            $display("FAIL fence_count: got %0d want %0d", count, base + 2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 9) < 3) begin
                    req_v[i]     = 1'b1;
                    cmds[i]      = rand_cmd();
                    req_fence[i] = ($urandom_range(0, 4) == 0);
                end else if (req_v[i] && $urandom_range(0, 19) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            ready   = ($urandom_range(0, 3) != 0);
            fence_i = ($urandom_range(0, 2) == 0);
            tick();
        end
        req_v     = '0;
        req_fence = '0;
        ready     = 1'b1;
        fence_i   = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (fe_v !== 1'b0 || supp !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain: got v=%b supp=%b want 0 0", fe_v, supp);
        end
    endtask

    task automatic test_timeout();
        int n;
        cmds[0]   = rand_cmd();
        req_fence = 4'b0001;
        ready     = 1'b1;
        fence_i   = 1'b1;
        req_v     = 4'b0001;
        tick();
        tick();
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (tmo === 1'b1) break;
        end
        n_cmp++;
        if (n != 255) begin
            n_err++;
            $display("FAIL timeout_cycles: got %0d want 255", n);
        end
        n_cmp++;
        if (fe_v !== 1'b0 || supp !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_idle: got v=%b supp=%b want 0 0", fe_v, supp);
        end
        fence_i   = 1'b0;
        req_fence = '0;
        cmds[3]   = rand_cmd();
        req_v     = 4'b1000;
        repeat (3) tick();
        n_cmp++;
        if (tmo !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got %b want 1", tmo);
        end
    endtask

    task automatic test_async_reset();
        cmds[2] = rand_cmd();
        ready   = 1'b0;
        req_v   = 4'b0100;
        tick();
        #1;
        n_cmp++;
        if (fe_v !== 1'b1) begin n_err++; $display("FAIL areset_pre: got v=%b want 1", fe_v); end
        reset_n = 1'b0;
        req_v   = 4'b0001;
        #1;
        n_cmp++;
        if (fe_v !== 1'b0 || count !== 16'd0 || tmo !== 1'b0 || yumi !== 4'b0000 || supp !== 1'b0) begin
            n_err++;
            $display("FAIL areset_now: got v=%b count=%0d tmo=%b yumi=%b supp=%b want all 0",
                     fe_v, count, tmo, yumi, supp);
        end
        req_v   = '0;
        #1;
        reset_n = 1'b1;
        model_reset();
        ready   = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (fe_v !== 1'b0 || count !== 16'd0) begin
            n_err++;
            $display("FAIL areset_after: got v=%b count=%0d want v=0 count=0", fe_v, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fence();
        test_random();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bp_be_fe_cmd_sequencer.md
Name: bp_be_fe_cmd_sequencer

Overview:
Sequences the single BE->FE command channel between several redirect and maintenance sources inside the checker: trap/xret redirect, branch-mispredict redirect, iTLB fill, and icache/itlb fence. It uses fixed-priority arbitration and holds the granted command until the FE accepts it. For fence-class commands, it waits for the FE fence to drain before issuing anything else. It also drives an issue-suppress signal so the scheduler stalls dispatch while a redirect is pending or in flight.

Parameters:
num_req_p, 4, number of command requesters; index 0 has the highest priority
fe_cmd_width_p, 109, width of one packed FE command
fence_timeout_p, 255, maximum cycles spent in fence wait before an error is flagged (8-bit counter)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_n_i  in  1  asynchronous reset, active-low
req_v_i  in  num_req_p  per-requester command valid
req_cmd_i  in  num_req_p*fe_cmd_width_p  per-requester command; slice i belongs to requester i
req_fence_i  in  num_req_p  per-requester flag: this command requires FE fence completion
req_yumi_o  out  num_req_p  one-hot; requester's command is consumed this cycle
fe_cmd_o  out  fe_cmd_width_p  command to FE
fe_cmd_v_o  out  1  command valid
fe_cmd_ready_i  in  1  FE can accept a command
fe_cmd_fence_i  in  1  FE is busy completing a fence
suppress_iss_o  out  1  stall issue
fence_timeout_o  out  1  sticky error flag
cmd_count_o  out  16  count of commands accepted by FE; wraps

Behaviour:
- Reset (asynchronous, while reset_n_i=0):
  - state goes to IDLE; hold register is zeroed; fence flag and timeout counter are cleared.
  - All outputs are 0: fe_cmd_v_o, req_yumi_o, suppress_iss_o, fence_timeout_o, cmd_count_o.
  - Reset mid-transfer drops fe_cmd_v_o immediately, with no clock edge required. The pending command is lost.
- Grant:
  - grant is the lowest-index set bit of req_v_i.
  - Grant is taken only when can_load = (state==IDLE) | (state==SEND & fe_cmd_ready_i & !hold_fence).
  - req_yumi_o = onehot(grant) & {num_req_p{can_load & |req_v_i}}. This is combinational, in the same cycle.
  - On yumi, the hold register captures the granted cmd slice, and hold_fence captures req_fence_i[grant].
- FSM states:
  - IDLE:
    - fe_cmd_v_o=0.
    - Any req_v_i -> grant -> SEND next cycle.
  - SEND:
    - fe_cmd_v_o=1; fe_cmd_o=hold.
    - hold is stable while !fe_cmd_ready_i; valid is never retracted.
    - ready & hold_fence -> FENCE_WAIT; timeout counter is cleared.
    - ready & !hold_fence & any req_v_i -> back-to-back grant, stay in SEND.
    - ready & no request -> IDLE.
  - FENCE_WAIT:
    - fe_cmd_v_o=0; minimum residency is 1 cycle; no grants.
    - fe_cmd_fence_i=0 sampled -> IDLE.
    - Otherwise the counter increments. If the counter equals fence_timeout_p, set fence_timeout_o (sticky until reset) and go to IDLE.
- Counters and outputs:
  - cmd_count_o increments by 1 on each fe_cmd_v_o & fe_cmd_ready_i; it wraps 0xFFFF->0x0000.
  - suppress_iss_o = (state!=IDLE) | (|req_v_i). It is combinational.
- Boundary conditions:
  - Simultaneous requests are served one per accepted command, highest priority first.
  - A lower-priority requester can starve under continuous higher-priority traffic; this is intended, since redirects dominate.
  - A request arriving in FENCE_WAIT waits and is not acknowledged.
  - A request that deasserts before yumi is simply not served; requesters must hold valid until yumi.
- Latency: request in IDLE -> fe_cmd_v_o the next cycle.

Test Plan:
1. Single request: req_v_i=4'b0100, cmd=C2, ready=1 -> yumi=4'b0100 in cycle 0; fe_cmd_v_o=1 with fe_cmd_o=C2 in cycle 1; IDLE in cycle 2; cmd_count_o=1.
2. Priority and back-to-back: req_v_i=4'b1010 held, ready=1 -> req1 is served in cycle 1 and req3 in cycle 2 with no bubble; cmd_count_o=2.
3. Backpressure: ready=0 for 5 cycles, then 1 -> fe_cmd_o is constant and valid for 6 cycles; exactly one count increment; no second yumi during the stall.
4. Fence: req0 with fence=1, FE raises fence_i for 3 cycles after accept -> FENCE_WAIT 3 cycles; a concurrent req1 is not yumi'd until IDLE; suppress_iss_o stays high throughout.
5. Timeout: fence_i held at 1 forever -> fence_timeout_o=1 after 255 wait cycles; FSM reaches IDLE; the flag stays set across later commands.
6. Async reset: drop reset_n_i mid-SEND between clock edges -> fe_cmd_v_o=0 immediately; cmd_count_o=0; after release, no command is issued without a new request.
